muldiv_unit: RTL

- Multi-cycle HI/LO multiply/divide engine and interlock controller for the MIPS core.
- Replaces the single-cycle combinational HI/LO update path in the execute stage.
- Sequences iterative shift-add multiplication and restoring division, and owns the HI and LO registers.
- Generates the pipeline stall when the core issues a new HI/LO operation, or reads HI/LO, while a calculation is in flight.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide engine with pipeline interlock.
// Optional Cancel port when MULDIV_CANCEL_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RdReq,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
`ifdef MULDIV_CANCEL_EN
  ,
  input  logic             Cancel
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_take;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             dz;
  logic             sgn;
  logic             cancel;
  logic             accept;
  logic             start_md;
  logic             start_mthi;
  logic             start_mtlo;

`ifdef MULDIV_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (cancel) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_md) state_n = CALC;
        CALC:    if (cnt == '0) state_n = FIX;
        FIX:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy       = (state != IDLE);
    Stall      = Busy & (Start | RdReq);
    accept     = Start & ~Busy & ~cancel;
    start_md   = accept & ~Op[2];
    start_mthi = accept & (Op == 3'd4);
    start_mtlo = accept & (Op == 3'd5);
  end

  // Signed ops (MULT/DIV) have Op[0]=0; work on magnitudes.
  always_comb begin
    sgn   = ~Op[0];
    a_mag = (sgn & A[WIDTH-1]) ? -A : A;
    b_mag = (sgn & B[WIDTH-1]) ? -B : B;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]}
             + (acc[0] ? {1'b0, m} : '0);
    div_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, m};
    div_take = div_sh[WIDTH] | ~div_diff[WIDTH];
    if (is_div) begin
      if (div_take)
        acc_step = {div_diff[WIDTH-1:0],
                    acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_sh[WIDTH-1:0],
                    acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    prod_fix = neg_res ? -acc : acc;
    q_fix    = neg_res ? -acc[WIDTH-1:0]
                       : acc[WIDTH-1:0];
    r_fix    = neg_rem ? -acc[W2-1:WIDTH]
                       : acc[W2-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      m       <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
    end else begin
      Done <= (state == FIX) & ~cancel;
      if (!cancel) begin
        if (start_md) begin
          is_div  <= Op[1];
          a_raw   <= A;
          cnt     <= CW'(WIDTH - 1);
          neg_res <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem <= sgn & A[WIDTH-1];
          dz      <= Op[1] & (B == '0);
          // mul: acc low = multiplier; div: acc low = dividend
          acc     <= {{WIDTH{1'b0}}, Op[1] ? a_mag : b_mag};
          m       <= Op[1] ? b_mag : a_mag;
        end
        if (start_mthi) HI <= A;
        if (start_mtlo) LO <= A;
        if (state == CALC) begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        if (state == FIX) begin
          if (is_div && dz) begin
            LO <= '1;
            HI <= a_raw;
          end else if (is_div) begin
            LO <= q_fix;
            HI <= r_fix;
          end else begin
            HI <= prod_fix[W2-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule
